// File: rtl/uart_cfg.sv
// uart_cfg: runtime-configurable UART (5-8 data bits, none/even/odd parity,
// 1 or 2 stop bits) with first-word-fall-through TX and RX queues.
//
// Parameters
//   FIFO_W    address bits of each queue (depth 2**FIFO_W)
//   OVS       baud ticks per bit; even, >= 8
// Ports
//   clk, reset            system clock, asynchronous active-low reset
//   dvsr                  baud divisor, one tick every dvsr+1 clocks
//   cfg_dbits/par/stop2   frame format, latched by TX and RX at frame start
//   wr_uart, w_data       push a character into the TX queue
//   rd_uart               pop the RX queue head
//   clr_err               clear the sticky error flags
//   rx / tx               serial input (asynchronous) / serial output
//   tx_full, tx_idle      TX queue full / queue empty and transmitter idle
//   rx_empty, r_data      RX queue empty / head character (right-aligned)
//   r_perr, r_ferr        parity / framing error of the head character
//   err_ovr/par/frm       sticky overrun, parity, framing flags
//   tx_state, rx_state    current state of the TX and RX machines
//
// Handshake: wr_uart and rd_uart are single-cycle strobes. A write is taken
// only while tx_full is low and a read only while rx_empty is low; a strobe
// against a full or empty queue is dropped with no side effect.
module uart_cfg #(
    parameter int FIFO_W = 4,
    parameter int OVS    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [20:0] dvsr,
    input  logic [1:0]  cfg_dbits,
    input  logic [1:0]  cfg_par,
    input  logic        cfg_stop2,
    input  logic        wr_uart,
    input  logic [7:0]  w_data,
    input  logic        rd_uart,
    input  logic        clr_err,
    input  logic        rx,
    output logic        tx,
    output logic        tx_full,
    output logic        tx_idle,
    output logic        rx_empty,
    output logic [7:0]  r_data,
    output logic        r_perr,
    output logic        r_ferr,
    output logic        err_ovr,
    output logic        err_par,
    output logic        err_frm,
    output logic [2:0]  tx_state,
    output logic [2:0]  rx_state
);
    localparam int DEPTH = 2 ** FIFO_W;
    localparam int CW    = $clog2(2 * OVS);
    localparam logic [CW-1:0] C_HALF = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] C_BIT  = CW'(OVS - 1);
    localparam logic [CW-1:0] C_TWO  = CW'(2 * OVS - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [FIFO_W:0] P_ONE = (FIFO_W + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // Mask of the active data bits for a given dbits code.
    function automatic logic [7:0] dmask(input logic [1:0] d);
        return 8'hFF >> (2'd3 - d);
    endfunction

    // ---------------- baud generator and rx synchroniser ----------------
    logic [20:0] b_cnt;
    logic        tick;
    logic        rx_m, rx_s;

    assign tick = (b_cnt == dvsr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_cnt <= '0;
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            // >= keeps the counter bounded if dvsr shrinks below the count
            b_cnt <= (b_cnt >= dvsr) ? '0 : b_cnt + 21'd1;
            rx_m  <= rx;
            rx_s  <= rx_m;
        end
    end

    // ---------------- queues (first-word fall-through) ----------------
    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [7:0]      tq_mem [DEPTH];
    logic [FIFO_W:0] tq_w, tq_r;
    logic            tq_empty, tx_done;
    logic [7:0]      tq_head;

    logic [9:0]      rq_mem [DEPTH];
    logic [FIFO_W:0] rq_w, rq_r;
    logic            rq_full, rx_push;
    logic [9:0]      rq_head, rx_wdata;

    assign tq_empty = (tq_w == tq_r);
    assign tx_full  = (tq_w[FIFO_W] != tq_r[FIFO_W]) && (tq_w[FIFO_W-1:0] == tq_r[FIFO_W-1:0]);
    assign tq_head  = tq_mem[tq_r[FIFO_W-1:0]];

    assign rx_empty = (rq_w == rq_r);
    assign rq_full  = (rq_w[FIFO_W] != rq_r[FIFO_W]) && (rq_w[FIFO_W-1:0] == rq_r[FIFO_W-1:0]);
    assign rq_head  = rq_mem[rq_r[FIFO_W-1:0]];

    always_ff @(posedge clk) begin
        if (wr_uart && !tx_full) tq_mem[tq_w[FIFO_W-1:0]] <= w_data;
        if (rx_push && !rq_full) rq_mem[rq_w[FIFO_W-1:0]] <= rx_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tq_w <= '0;
            tq_r <= '0;
            rq_w <= '0;
            rq_r <= '0;
        end else begin
            if (wr_uart && !tx_full)   tq_w <= tq_w + P_ONE;
            if (tx_done && !tq_empty)  tq_r <= tq_r + P_ONE;
            if (rx_push && !rq_full)   rq_w <= rq_w + P_ONE;
            if (rd_uart && !rx_empty)  rq_r <= rq_r + P_ONE;
        end
    end

    // Head contents are undefined while empty, so present zeros instead.
    assign r_data = rx_empty ? 8'h00 : rq_head[7:0];
    assign r_ferr = !rx_empty && rq_head[8];
    assign r_perr = !rx_empty && rq_head[9];

    // ---------------- transmitter ----------------
    state_t         tx_st;
    logic [CW-1:0]  tx_cnt;
    logic [2:0]     tx_n;
    logic [7:0]     tx_shift;
    logic [1:0]     tx_dbits;
    logic           tx_pbit, tx_pen, tx_stop2, tx_reg;

    assign tx       = tx_reg;
    assign tx_idle  = tq_empty && (tx_st == S_IDLE);
    assign tx_state = tx_st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_st    <= S_IDLE;
            tx_cnt   <= '0;
            tx_n     <= '0;
            tx_shift <= '0;
            tx_dbits <= '0;
            tx_pbit  <= 1'b0;
            tx_pen   <= 1'b0;
            tx_stop2 <= 1'b0;
            tx_reg   <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_st)
                S_IDLE: begin
                    tx_reg <= 1'b1;
                    // tx_done still high means the pop has not landed yet;
                    // waiting one clock avoids resending the old head.
                    if (!tq_empty && !tx_done) begin
                        tx_shift <= tq_head;
                        tx_pbit  <= (^(tq_head & dmask(cfg_dbits))) ^ (cfg_par == 2'b10);
                        tx_dbits <= cfg_dbits;
                        tx_pen   <= ^cfg_par;
                        tx_stop2 <= cfg_stop2;
                        tx_cnt   <= '0;
                        tx_reg   <= 1'b0;
                        tx_st    <= S_START;
                    end
                end
                S_START: if (tick) begin
                    if (tx_cnt == C_BIT) begin
                        tx_cnt <= '0;
                        tx_n   <= '0;
                        tx_reg <= tx_shift[0];
                        tx_st  <= S_DATA;
                    end else tx_cnt <= tx_cnt + C_ONE;
                end
                S_DATA: if (tick) begin
                    if (tx_cnt == C_BIT) begin
                        tx_cnt   <= '0;
                        tx_shift <= tx_shift >> 1;
                        // last data bit index is dbits+4, i.e. {1, dbits}
                        if (tx_n == {1'b1, tx_dbits}) begin
                            tx_reg <= tx_pen ? tx_pbit : 1'b1;
                            tx_st  <= tx_pen ? S_PAR : S_STOP;
                        end else begin
                            tx_n   <= tx_n + 3'd1;
                            tx_reg <= tx_shift[1];
                        end
                    end else tx_cnt <= tx_cnt + C_ONE;
                end
                S_PAR: if (tick) begin
                    if (tx_cnt == C_BIT) begin
                        tx_cnt <= '0;
                        tx_reg <= 1'b1;
                        tx_st  <= S_STOP;
                    end else tx_cnt <= tx_cnt + C_ONE;
                end
                S_STOP: if (tick) begin
                    if (tx_cnt == (tx_stop2 ? C_TWO : C_BIT)) begin
                        tx_cnt  <= '0;
                        tx_done <= 1'b1;
                        tx_st   <= S_IDLE;
                    end else tx_cnt <= tx_cnt + C_ONE;
                end
                default: tx_st <= S_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    state_t         rx_st;
    logic [CW-1:0]  rx_cnt;
    logic [2:0]     rx_n;
    logic [7:0]     rx_shift;
    logic [1:0]     rx_dbits;
    logic           rx_pen, rx_odd, rx_perr;

    assign rx_state = rx_st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_st    <= S_IDLE;
            rx_cnt   <= '0;
            rx_n     <= '0;
            rx_shift <= '0;
            rx_dbits <= '0;
            rx_pen   <= 1'b0;
            rx_odd   <= 1'b0;
            rx_perr  <= 1'b0;
            rx_push  <= 1'b0;
            rx_wdata <= '0;
        end else begin
            rx_push <= 1'b0;
            case (rx_st)
                S_IDLE: if (!rx_s) begin
                    rx_cnt   <= '0;
                    rx_n     <= '0;
                    rx_shift <= '0;
                    rx_perr  <= 1'b0;
                    rx_dbits <= cfg_dbits;
                    rx_pen   <= ^cfg_par;
                    rx_odd   <= (cfg_par == 2'b10);
                    rx_st    <= S_START;
                end
                S_START: if (tick) begin
                    if (rx_cnt == C_HALF) begin
                        rx_cnt <= '0;
                        rx_st  <= rx_s ? S_IDLE : S_DATA;
                    end else rx_cnt <= rx_cnt + C_ONE;
                end
                S_DATA: if (tick) begin
                    if (rx_cnt == C_BIT) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (rx_n == {1'b1, rx_dbits}) rx_st <= rx_pen ? S_PAR : S_STOP;
                        else                          rx_n  <= rx_n + 3'd1;
                    end else rx_cnt <= rx_cnt + C_ONE;
                end
                S_PAR: if (tick) begin
                    if (rx_cnt == C_BIT) begin
                        rx_cnt  <= '0;
                        // unused low bits of rx_shift are zero, so ^ covers data only
                        rx_perr <= rx_s ^ (^rx_shift) ^ rx_odd;
                        rx_st   <= S_STOP;
                    end else rx_cnt <= rx_cnt + C_ONE;
                end
                S_STOP: if (tick) begin
                    if (rx_cnt == C_BIT) begin
                        rx_cnt   <= '0;
                        rx_push  <= 1'b1;
                        // short frames arrive in the top bits; right-align them
                        rx_wdata <= {rx_perr, !rx_s, rx_shift >> (2'd3 - rx_dbits)};
                        rx_st    <= S_IDLE;
                    end else rx_cnt <= rx_cnt + C_ONE;
                end
                default: rx_st <= S_IDLE;
            endcase
        end
    end

    // ---------------- sticky error flags ----------------
    // Set is written after clear so a same-clock event wins over clr_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_ovr <= 1'b0;
            err_par <= 1'b0;
            err_frm <= 1'b0;
        end else begin
            if (clr_err) begin
                err_ovr <= 1'b0;
                err_par <= 1'b0;
                err_frm <= 1'b0;
            end
            if (rx_push) begin
                if (rq_full)     err_ovr <= 1'b1;
                if (rx_wdata[9]) err_par <= 1'b1;
                if (rx_wdata[8]) err_frm <= 1'b1;
            end
        end
    end
endmodule
